// File: rtl/intr_ctrl_pkg.sv
// intr_ctrl_pkg: channel state encoding and shared defaults for the interrupt controller.
package intr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_CLEAR  = 2'd3
  } chan_state_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int TIMEOUT_DEF     = 255;

  // Clear-wait counter width: 8 bits covers the usual limits, 16 for longer ones.
  function automatic int cnt_width(input int limit);
    return (limit < 256) ? 8 : 16;
  endfunction

endpackage

// File: rtl/intr_ctrl_chan.sv
// intr_ctrl_chan: one interrupt channel -- input synchronizer, request FSM, registered clear.
// Optional clear-wait timeout is built when INTR_CTRL_TIMEOUT_EN is defined.
//
// state     | meaning
// ST_IDLE   | no request being tracked
// ST_PEND   | synchronized request seen while enabled, waiting for a claim
// ST_ACTIVE | claimed by the CPU, waiting for completion
// ST_CLEAR  | clr driven to the source until its request is seen low
module intr_ctrl_chan
  import intr_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
`ifdef INTR_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT     = TIMEOUT_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  input  logic en,
  input  logic claim,
  input  logic complete,
  output logic pend,
  output logic active,
  output logic clr,
  output logic timeout_err
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   timeout_hit;
  chan_state_e            state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (s && en) state_nxt = ST_PEND;
      ST_PEND:   if (claim) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (complete) state_nxt = ST_CLEAR;
      ST_CLEAR:  if (!s || timeout_hit) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign pend   = (state == ST_PEND);
  assign active = (state == ST_ACTIVE);
  assign clr    = (state == ST_CLEAR);

`ifdef INTR_CTRL_TIMEOUT_EN
  localparam int CW = cnt_width(TIMEOUT);

  logic [CW-1:0] cnt;
  logic          err_q;

  // Counter sits at zero outside CLEAR, so it starts from zero on every entry.
  assign timeout_hit = (state == ST_CLEAR) && s && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt <= (state == ST_CLEAR) ? cnt + 1'b1 : '0;
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: N-channel interrupt collector with lowest-index priority and claim/complete handshake.
// Define INTR_CTRL_TIMEOUT_EN to build the per-channel clear-wait timeout.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int N           = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int IDW         = (N > 1) ? $clog2(N) : 1,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   irq_in,
  input  logic [N-1:0]   en,
  output logic [N-1:0]   clr,
  output logic           cpu_irq,
  output logic [IDW-1:0] cpu_id,
  input  logic           cpu_claim,
  input  logic           cpu_complete,
  input  logic [IDW-1:0] cpu_complete_id,
  output logic [N-1:0]   active,
  output logic [N-1:0]   timeout_err
);

  logic [N-1:0] pend;
  logic [N-1:0] claim_hit;
  logic [N-1:0] complete_hit;

  // Walk from the top so the lowest pending index wins.
  always_comb begin
    cpu_irq = 1'b0;
    cpu_id  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend[i] && en[i]) begin
        cpu_irq = 1'b1;
        cpu_id  = IDW'(i);
      end
    end
  end

  always_comb begin
    claim_hit    = '0;
    complete_hit = '0;
    for (int i = 0; i < N; i++) begin
      claim_hit[i]    = cpu_claim && cpu_irq && (cpu_id == IDW'(i));
      complete_hit[i] = cpu_complete && (cpu_complete_id == IDW'(i));
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_chan
    intr_ctrl_chan #(
      .SYNC_STAGES(SYNC_STAGES)
`ifdef INTR_CTRL_TIMEOUT_EN
      ,
      .TIMEOUT    (TIMEOUT)
`endif
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .irq_in     (irq_in[g]),
      .en         (en[g]),
      .claim      (claim_hit[g]),
      .complete   (complete_hit[g]),
      .pend       (pend[g]),
      .active     (active[g]),
      .clr        (clr[g]),
      .timeout_err(timeout_err[g])
    );
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed scenarios plus randomized traffic checked against a set-based reference model.
module tb_intr_ctrl;

  localparam int N   = 8;
  localparam int SS  = 2;
  localparam int IDW = 3;
`ifdef INTR_CTRL_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   irq_in, en, clr, active, timeout_err;
  logic           cpu_irq, cpu_claim, cpu_complete;
  logic [IDW-1:0] cpu_id, cpu_complete_id;

  int checks = 0;
  int errors = 0;

  // Reference model: the sync pipeline as a delay line, and channel status as sets.
  logic [N-1:0] m_sync [SS];
  logic [N-1:0] m_pend, m_act, m_clr, m_err;
  int           m_age [N];

  intr_ctrl #(.N(N), .SYNC_STAGES(SS), .IDW(IDW), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .irq_in         (irq_in),
    .en             (en),
    .clr            (clr),
    .cpu_irq        (cpu_irq),
    .cpu_id         (cpu_id),
    .cpu_claim      (cpu_claim),
    .cpu_complete   (cpu_complete),
    .cpu_complete_id(cpu_complete_id),
    .active         (active),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_edge();
    logic [N-1:0] s, cand, np, na, nc;
    int id;
    bit irq;
    if (rst) begin
      for (int k = 0; k < SS; k++) m_sync[k] = '0;
      m_pend = '0; m_act = '0; m_clr = '0; m_err = '0;
      for (int i = 0; i < N; i++) m_age[i] = 0;
      return;
    end
    s = m_sync[SS-1];
    cand = m_pend & en;
    irq = (cand != '0);
    id = lowest(cand);
    np = m_pend; na = m_act; nc = m_clr;
    for (int i = 0; i < N; i++) begin
      if (!(m_pend[i] || m_act[i] || m_clr[i]) && s[i] && en[i]) np[i] = 1'b1;
      if (m_pend[i] && cpu_claim && irq && id == i) begin np[i] = 1'b0; na[i] = 1'b1; end
      if (m_act[i] && cpu_complete && int'(cpu_complete_id) == i) begin
        na[i] = 1'b0; nc[i] = 1'b1; m_age[i] = 0;
      end
      if (m_clr[i]) begin
        if (!s[i]) nc[i] = 1'b0;
`ifdef INTR_CTRL_TIMEOUT_EN
        else if (m_age[i] + 1 == TO) begin nc[i] = 1'b0; m_err[i] = 1'b1; end
        else m_age[i]++;
`endif
      end
    end
    m_pend = np; m_act = na; m_clr = nc;
    for (int k = SS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
    m_sync[0] = irq_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_claim();
    cpu_claim = 1'b1; tick(); cpu_claim = 1'b0;
  endtask

  task automatic pulse_complete(input int id);
    cpu_complete = 1'b1; cpu_complete_id = IDW'(id); tick(); cpu_complete = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; ticks(2); rst = 1'b0;
  endtask

  task automatic test_reset();
    irq_in = '0; en = '0; cpu_claim = 0; cpu_complete = 0; cpu_complete_id = '0;
    do_reset();
    checks++; if (clr !== 8'h00) begin errors++; $display("FAIL reset_clr: got %h want 00", clr); end
    checks++; if (active !== 8'h00) begin errors++; $display("FAIL reset_active: got %h want 00", active); end
    checks++; if (cpu_irq !== 1'b0 || cpu_id !== 3'd0) begin errors++; $display("FAIL reset_cpu: irq=%b id=%0d want 0/0", cpu_irq, cpu_id); end
    checks++; if (timeout_err !== 8'h00) begin errors++; $display("FAIL reset_terr: got %h want 00", timeout_err); end
  endtask

  task automatic test_single();
    en = 8'hFF; irq_in[3] = 1'b1;
    ticks(2);
    checks++; if (cpu_irq !== 1'b0) begin errors++; $display("FAIL single_early: cpu_irq=%b want 0 after 2 edges", cpu_irq); end
    tick();
    checks++; if (cpu_irq !== 1'b1 || cpu_id !== 3'd3) begin errors++; $display("FAIL single_latency: irq=%b id=%0d want 1/3", cpu_irq, cpu_id); end
    pulse_claim();
    checks++; if (active !== 8'h08 || cpu_irq !== 1'b0) begin errors++; $display("FAIL single_claim: active=%h irq=%b want 08/0", active, cpu_irq); end
    pulse_complete(3);
    checks++; if (clr !== 8'h08 || active !== 8'h00) begin errors++; $display("FAIL single_complete: clr=%h active=%h want 08/00", clr, active); end
    irq_in[3] = 1'b0;
    ticks(2);
    checks++; if (clr !== 8'h08) begin errors++; $display("FAIL single_clr_hold: clr=%h want 08", clr); end
    tick();
    checks++; if (clr !== 8'h00) begin errors++; $display("FAIL single_clr_drop: clr=%h want 00", clr); end
  endtask

  task automatic test_priority();
    irq_in[5] = 1'b1; irq_in[2] = 1'b1;
    ticks(3);
    checks++; if (cpu_irq !== 1'b1 || cpu_id !== 3'd2) begin errors++; $display("FAIL prio_first: irq=%b id=%0d want 1/2", cpu_irq, cpu_id); end
    pulse_claim();
    checks++; if (cpu_irq !== 1'b1 || cpu_id !== 3'd5) begin errors++; $display("FAIL prio_second: irq=%b id=%0d want 1/5", cpu_irq, cpu_id); end
    pulse_claim();
    checks++; if (cpu_irq !== 1'b0 || active !== 8'h24) begin errors++; $display("FAIL prio_nested: irq=%b active=%h want 0/24", cpu_irq, active); end
    pulse_complete(5);
    pulse_complete(2);
    checks++; if (clr !== 8'h24 || active !== 8'h00) begin errors++; $display("FAIL prio_clr: clr=%h active=%h want 24/00", clr, active); end
    irq_in = '0;
    ticks(3);
    checks++; if (clr !== 8'h00) begin errors++; $display("FAIL prio_idle: clr=%h want 00", clr); end
  endtask

  task automatic test_masking();
    int seen = 0;
    en = 8'hFD; irq_in[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (cpu_irq !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mask_hidden: cpu_irq high on %0d of 20 cycles want 0", seen); end
    en = 8'hFF;
    tick();
    checks++; if (cpu_irq !== 1'b1 || cpu_id !== 3'd1) begin errors++; $display("FAIL mask_enable: irq=%b id=%0d want 1/1", cpu_irq, cpu_id); end
    // Masking a pending channel hides it without losing it.
    en = 8'hFD;
    tick();
    checks++; if (cpu_irq !== 1'b0) begin errors++; $display("FAIL mask_pend_hidden: irq=%b want 0", cpu_irq); end
    en = 8'hFF;
    tick();
    checks++; if (cpu_irq !== 1'b1 || cpu_id !== 3'd1) begin errors++; $display("FAIL mask_pend_back: irq=%b id=%0d want 1/1", cpu_irq, cpu_id); end
    pulse_claim(); pulse_complete(1);
    irq_in[1] = 1'b0;
    ticks(3);
  endtask

  task automatic test_bogus();
    pulse_complete(4);
    checks++; if (clr !== 8'h00 || active !== 8'h00) begin errors++; $display("FAIL bogus_complete: clr=%h active=%h want 00/00", clr, active); end
    pulse_claim();
    checks++; if (active !== 8'h00) begin errors++; $display("FAIL bogus_claim: active=%h want 00", active); end
  endtask

  task automatic test_back_to_back();
    irq_in[2] = 1'b1;
    ticks(3);
    pulse_claim();
    irq_in[6] = 1'b1;
    ticks(3);
    cpu_claim = 1'b1; cpu_complete = 1'b1; cpu_complete_id = 3'd2;
    tick();
    cpu_claim = 1'b0; cpu_complete = 1'b0;
    checks++; if (active !== 8'h40 || clr !== 8'h04) begin errors++; $display("FAIL b2b_both: active=%h clr=%h want 40/04", active, clr); end
    pulse_complete(6);
    irq_in = '0;
    ticks(3);
    checks++; if (clr !== 8'h00 || active !== 8'h00) begin errors++; $display("FAIL b2b_idle: clr=%h active=%h want 00/00", clr, active); end
  endtask

  task automatic test_reset_mid();
    irq_in[0] = 1'b1;
    ticks(3);
    pulse_claim(); pulse_complete(0);
    checks++; if (clr !== 8'h01) begin errors++; $display("FAIL rstmid_clear: clr=%h want 01", clr); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (clr !== 8'h00 || active !== 8'h00 || cpu_irq !== 1'b0) begin errors++; $display("FAIL rstmid_drop: clr=%h active=%h irq=%b want 00/00/0", clr, active, cpu_irq); end
    ticks(3);
    checks++; if (cpu_irq !== 1'b1 || cpu_id !== 3'd0) begin errors++; $display("FAIL rstmid_repend: irq=%b id=%0d want 1/0", cpu_irq, cpu_id); end
    pulse_claim(); pulse_complete(0);
    irq_in[0] = 1'b0;
    ticks(3);
  endtask

  task automatic test_stuck_clear();
    irq_in[7] = 1'b1;
    ticks(3);
    pulse_claim(); pulse_complete(7);
`ifdef INTR_CTRL_TIMEOUT_EN
    ticks(TO - 1);
    checks++; if (clr !== 8'h80 || timeout_err !== 8'h00) begin errors++; $display("FAIL timeout_before: clr=%h terr=%h want 80/00", clr, timeout_err); end
    tick();
    checks++; if (clr !== 8'h00 || timeout_err !== 8'h80) begin errors++; $display("FAIL timeout_fire: clr=%h terr=%h want 00/80", clr, timeout_err); end
    irq_in[7] = 1'b0;
    ticks(20);
    checks++; if (timeout_err !== 8'h80) begin errors++; $display("FAIL timeout_sticky: terr=%h want 80", timeout_err); end
`else
    ticks(300);
    checks++; if (clr !== 8'h80 || timeout_err !== 8'h00) begin errors++; $display("FAIL stuck_hold: clr=%h terr=%h want 80/00", clr, timeout_err); end
    irq_in[7] = 1'b0;
`endif
    do_reset();
    checks++; if (clr !== 8'h00 || timeout_err !== 8'h00) begin errors++; $display("FAIL stuck_reset: clr=%h terr=%h want 00/00", clr, timeout_err); end
  endtask

  task automatic test_random();
    int bad = 0;
    int first = -1;
    logic [N-1:0] cand;
    logic [IDW-1:0] exp_id;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_clr[i] && $urandom_range(3) != 0) irq_in[i] = 1'b0;
        else if ($urandom_range(15) == 0) irq_in[i] = ~irq_in[i];
      end
      en = ($urandom_range(7) == 0) ? N'($urandom) : '1;
      cpu_claim = ($urandom_range(2) == 0);
      cpu_complete = ($urandom_range(2) == 0);
      if (m_act != '0 && $urandom_range(3) != 0) begin
        int pick;
        do pick = $urandom_range(N - 1); while (!m_act[pick]);
        cpu_complete_id = IDW'(pick);
      end else cpu_complete_id = IDW'($urandom);
      rst = ($urandom_range(499) == 0);
      tick();
      cand = m_pend & en;
      exp_id = IDW'(lowest(cand));
      checks++;
      if (cpu_irq !== (cand != '0) || cpu_id !== exp_id || active !== m_act ||
          clr !== m_clr || timeout_err !== m_err) begin
        errors++;
        bad++;
        if (bad <= 5)
          $display("FAIL random_cycle%0d: irq=%b id=%0d act=%h clr=%h terr=%h want %b/%0d/%h/%h/%h",
                   c, cpu_irq, cpu_id, active, clr, timeout_err, (cand != '0), exp_id, m_act, m_clr, m_err);
        if (first < 0) first = c;
      end
    end
    cpu_claim = 0; cpu_complete = 0; rst = 0;
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_priority();
    test_masking();
    test_bogus();
    test_back_to_back();
    test_reset_mid();
    test_stuck_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
